// File: rtl/tt_sel_ctrl_pkg.sv
// Shared types and constants for the mux4 select-tree control stage.
//   sel_state_e     : select FSM encoding (IDLE=0, SETTLE=1, ACTIVE=2)
//   SYNC_RST_*      : reset level of each pad synchroniser
//   settle_cnt_w()  : settle counter width for a given SETTLE_CYC
package tt_sel_ctrl_pkg;

    typedef enum logic [1:0] {
        SEL_IDLE   = 2'd0,
        SEL_SETTLE = 2'd1,
        SEL_ACTIVE = 2'd2
    } sel_state_e;

    // Reset levels chosen so that a reset looks like "no request, no clear".
    localparam logic SYNC_RST_INC  = 1'b0;
    localparam logic SYNC_RST_ENA  = 1'b0;
    localparam logic SYNC_RST_RSTN = 1'b1;

    // Smallest width able to hold settle_cyc-1, never less than one bit.
    function automatic int unsigned settle_cnt_w(input int unsigned settle_cyc);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < settle_cyc) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/tt_prim_sync.sv
// Two-flop synchroniser for one asynchronous pad with a selectable reset value.
// Ports:
//   clk    : destination clock
//   rst    : synchronous active-high reset, loads RST_VAL into both flops
//   d_i    : asynchronous input
//   q_o    : synchronised output (two clk edges of latency)
module tt_prim_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Metastability capture flop followed by the resolving flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/tt_mux_sel_ctrl.sv
// Select control for the tt_prim_mux4 trees: synchronises the three control
// pads, turns inc rising edges into a wrapping design address and sequences
// the tree output enable so a half-switched tree is never enabled.
// Optional feature macro: TT_SEL_CTRL_DEGLITCH_EN (inc must be high for two
// synced cycles before it counts; adds one edge of inc latency).
// Ports:
//   clk            : clock
//   rst            : synchronous active-high reset
//   ctrl_sel_rst_n : async pad, low holds the address at 0
//   ctrl_sel_inc   : async pad, each rising edge increments the address
//   ctrl_ena       : async pad, request to enable the selected design
//   sel_addr       : registered address, pair [2k+1:2k] drives tree level k
//   sel_ena        : registered tree output enable
//   busy           : high while settling
module tt_mux_sel_ctrl
    import tt_sel_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_sel_rst_n,
    input  logic              ctrl_sel_inc,
    input  logic              ctrl_ena,
    output logic [ADDR_W-1:0] sel_addr,
    output logic              sel_ena,
    output logic              busy
);

    localparam int unsigned      CNT_W    = settle_cnt_w(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    logic inc_s;
    logic ena_s;
    logic rstn_s;

    logic inc_hist_q;
    logic inc_rise;
    logic inc_pls_q;
    logic clr_q;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              addr_chg;

    sel_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              sel_ena_q;
    logic              busy_q;

    // Pad synchronisers
    tt_prim_sync #(.RST_VAL(SYNC_RST_INC)) u_sync_inc (
        .clk (clk),
        .rst (rst),
        .d_i (ctrl_sel_inc),
        .q_o (inc_s)
    );

    tt_prim_sync #(.RST_VAL(SYNC_RST_ENA)) u_sync_ena (
        .clk (clk),
        .rst (rst),
        .d_i (ctrl_ena),
        .q_o (ena_s)
    );

    tt_prim_sync #(.RST_VAL(SYNC_RST_RSTN)) u_sync_rstn (
        .clk (clk),
        .rst (rst),
        .d_i (ctrl_sel_rst_n),
        .q_o (rstn_s)
    );

`ifdef TT_SEL_CTRL_DEGLITCH_EN
    logic inc_hist2_q;

    // Second history flop: a rise needs two consecutive synced highs.
    always_ff @(posedge clk) begin
        if (rst) begin
            inc_hist2_q <= SYNC_RST_INC;
        end else begin
            inc_hist2_q <= inc_hist_q;
        end
    end

    assign inc_rise = inc_s & inc_hist_q & ~inc_hist2_q;
`else
    assign inc_rise = inc_s & ~inc_hist_q;
`endif

    // Edge history, plus the increment and clear requests registered together
    // so the level clear masks every rise it overlaps, including at release.
    always_ff @(posedge clk) begin
        if (rst) begin
            inc_hist_q <= SYNC_RST_INC;
            inc_pls_q  <= 1'b0;
            clr_q      <= ~SYNC_RST_RSTN;
        end else begin
            inc_hist_q <= inc_s;
            inc_pls_q  <= inc_rise;
            clr_q      <= ~rstn_s;
        end
    end

    // Address next value: clear beats increment.
    always_comb begin
        addr_d = addr_q;
        if (clr_q) begin
            addr_d = '0;
        end else if (inc_pls_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    // Clearing an already-zero address is not a change.
    assign addr_chg = (addr_d != addr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Enable sequencing FSM. It sees addr_chg in the same cycle the address
    // register is written, so sel_ena drops on the edge the new address lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEL_IDLE;
            cnt_q     <= '0;
            sel_ena_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                SEL_IDLE: begin
                    if (ena_s) begin
                        state_q <= SEL_SETTLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SEL_SETTLE: begin
                    if (!ena_s) begin
                        state_q <= SEL_IDLE;
                        busy_q  <= 1'b0;
                    end else if (addr_chg) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= SEL_ACTIVE;
                        sel_ena_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SEL_ACTIVE: begin
                    if (!ena_s) begin
                        state_q   <= SEL_IDLE;
                        sel_ena_q <= 1'b0;
                    end else if (addr_chg) begin
                        state_q   <= SEL_SETTLE;
                        cnt_q     <= '0;
                        sel_ena_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= SEL_IDLE;
                    cnt_q     <= '0;
                    sel_ena_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign sel_addr = addr_q;
    assign sel_ena  = sel_ena_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_tt_mux_sel_ctrl.sv
// Scoreboard bench for tt_mux_sel_ctrl. Two instances share the pads:
// u_dut (ADDR_W=10, SETTLE_CYC=4) and u_dut4 (ADDR_W=4, SETTLE_CYC=1).
// Expected output values are queued against the edge number at which they
// must be visible and compared on the following falling edge.
module tb_tt_mux_sel_ctrl;

`ifdef TT_SEL_CTRL_DEGLITCH_EN
    localparam int unsigned LAT           = 4;
    localparam bit          GLITCH_COUNTS = 1'b0;
`else
    localparam int unsigned LAT           = 3;
    localparam bit          GLITCH_COUNTS = 1'b1;
`endif

    localparam int unsigned K_A10 = 0;
    localparam int unsigned K_E10 = 1;
    localparam int unsigned K_B10 = 2;
    localparam int unsigned K_A4  = 3;
    localparam int unsigned K_E4  = 4;
    localparam int unsigned K_B4  = 5;

    typedef struct {
        int unsigned edge_n;
        int unsigned kind;
        logic [31:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       pad_rst_n;
    logic       pad_inc;
    logic       pad_ena;
    logic [9:0] sel_addr;
    logic       sel_ena;
    logic       busy;
    logic [3:0] sel_addr4;
    logic       sel_ena4;
    logic       busy4;

    int unsigned edge_cnt = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned m_addr   = 0;
    exp_t        sb_q[$];

    logic [9:0] hist10 [4];
    logic [3:0] hist4;

    tt_mux_sel_ctrl #(.ADDR_W(10), .SETTLE_CYC(4)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .ctrl_sel_rst_n (pad_rst_n),
        .ctrl_sel_inc   (pad_inc),
        .ctrl_ena       (pad_ena),
        .sel_addr       (sel_addr),
        .sel_ena        (sel_ena),
        .busy           (busy)
    );

    tt_mux_sel_ctrl #(.ADDR_W(4), .SETTLE_CYC(1)) u_dut4 (
        .clk            (clk),
        .rst            (rst),
        .ctrl_sel_rst_n (pad_rst_n),
        .ctrl_sel_inc   (pad_inc),
        .ctrl_ena       (pad_ena),
        .sel_addr       (sel_addr4),
        .sel_ena        (sel_ena4),
        .busy           (busy4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    function automatic logic [31:0] obs(input int unsigned k);
        case (k)
            K_A10:   obs = 32'(sel_addr);
            K_E10:   obs = 32'(sel_ena);
            K_B10:   obs = 32'(busy);
            K_A4:    obs = 32'(sel_addr4);
            K_E4:    obs = 32'(sel_ena4);
            K_B4:    obs = 32'(busy4);
            default: obs = 'x;
        endcase
    endfunction

    function automatic string kind_name(input int unsigned k);
        case (k)
            K_A10:   kind_name = "addr10";
            K_E10:   kind_name = "ena10";
            K_B10:   kind_name = "busy10";
            K_A4:    kind_name = "addr4";
            K_E4:    kind_name = "ena4";
            K_B4:    kind_name = "busy4";
            default: kind_name = "unknown";
        endcase
    endfunction

    task automatic push(input int unsigned e, input int unsigned k, input int unsigned v);
        exp_t x;
        x.edge_n = e;
        x.kind   = k;
        x.val    = 32'(v);
        sb_q.push_back(x);
    endtask

    task automatic push_addr(input int unsigned e, input int unsigned a);
        push(e, K_A10, a % 1024);
        push(e, K_A4, a % 16);
    endtask

    // Output monitor: scoreboard compare plus the enable-vs-address invariant.
    always @(negedge clk) begin
        for (int i = int'(sb_q.size()) - 1; i >= 0; i--) begin
            if (sb_q[i].edge_n == edge_cnt) begin
                check_eq(kind_name(sb_q[i].kind), obs(sb_q[i].kind), sb_q[i].val);
                sb_q.delete(i);
            end else if (sb_q[i].edge_n < edge_cnt) begin
                check_eq("sb_stale", 32'(edge_cnt), 32'(sb_q[i].edge_n));
                sb_q.delete(i);
            end
        end
        if (sel_ena) check_eq("ena_addr_stable10", 32'(sel_addr), 32'(hist10[3]));
        if (sel_ena4) check_eq("ena_addr_stable4", 32'(sel_addr4), 32'(hist4));
        hist10[3] <= hist10[2];
        hist10[2] <= hist10[1];
        hist10[1] <= hist10[0];
        hist10[0] <= sel_addr;
        hist4     <= sel_addr4;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise inc; pad is first sampled at edge n. Queues the address checks.
    task automatic inc_start(input int unsigned hi, input int unsigned lo, input bit counts,
                             output int unsigned n);
        int unsigned old;
        step();
        pad_inc = 1'b1;
        n       = edge_cnt + 1;
        old     = m_addr;
        if (counts) m_addr = m_addr + 1;
        push_addr(n + LAT - 1, old);
        push_addr(n + LAT, m_addr);
        push_addr(n + hi + lo - 2, m_addr);
    endtask

    task automatic inc_hold(input int unsigned hi, input int unsigned lo);
        repeat (hi) step();
        pad_inc = 1'b0;
        repeat (lo) step();
    endtask

    task automatic inc_pulse(input int unsigned hi, input int unsigned lo, input bit counts);
        int unsigned n;
        inc_start(hi, lo, counts, n);
        inc_hold(hi, lo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        bit          found;
        logic        prev_ena;

        rst       = 1'b1;
        pad_rst_n = 1'b1;
        pad_inc   = 1'b0;
        pad_ena   = 1'b0;
        for (int e = 1; e <= 2; e++) begin
            push_addr(e, 0);
            push(e, K_E10, 0);
            push(e, K_B10, 0);
            push(e, K_E4, 0);
            push(e, K_B4, 0);
        end
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Five counted pulses with enable low.
        repeat (5) begin
            inc_start(4, 4, 1'b1, n);
            push(n + LAT, K_E10, 0);
            inc_hold(4, 4);
        end

        // Count up to 15, then wrap the 4-bit instance; then a long high.
        repeat (10) inc_pulse(4, 4, 1'b1);
        inc_pulse(4, 4, 1'b1);
        inc_pulse(20, 4, 1'b1);

        // Enable with a stable address.
        step();
        pad_ena = 1'b1;
        n = edge_cnt + 1;
        push(n + 1, K_B10, 0);
        push(n + 2, K_B10, 1);
        push(n + 5, K_B10, 1);
        push(n + 5, K_E10, 0);
        push(n + 6, K_E10, 1);
        push(n + 6, K_B10, 0);
        push(n + 2, K_E4, 0);
        push(n + 2, K_B4, 1);
        push(n + 3, K_E4, 1);
        repeat (10) step();

        // Increment while active: break-before-make then re-settle.
        inc_start(4, 4, 1'b1, n);
        push(n + LAT - 1, K_E10, 1);
        push(n + LAT, K_E10, 0);
        push(n + LAT, K_B10, 1);
        push(n + LAT + 3, K_E10, 0);
        push(n + LAT + 4, K_E10, 1);
        push(n + LAT, K_E4, 0);
        push(n + LAT + 1, K_E4, 1);
        inc_hold(4, 4);
        repeat (4) step();

        // Enable pad falling.
        step();
        pad_ena = 1'b0;
        n = edge_cnt + 1;
        push(n + 1, K_E10, 1);
        push(n + 2, K_E10, 0);
        push(n + 1, K_E4, 1);
        push(n + 2, K_E4, 0);
        repeat (6) step();

        // Address clear pad holds 0 and masks increments.
        pad_rst_n = 1'b0;
        m_addr    = 0;
        repeat (8) step();
        push_addr(edge_cnt + 1, 0);
        repeat (3) inc_pulse(4, 4, 1'b0);
        pad_rst_n = 1'b1;
        repeat (8) step();
        push_addr(edge_cnt + 1, 0);
        step();

        // Address 7, active, then clear: enable drops with the clear.
        repeat (7) inc_pulse(4, 4, 1'b1);
        step();
        pad_ena = 1'b1;
        repeat (10) step();
        push(edge_cnt + 1, K_E10, 1);
        push(edge_cnt + 1, K_E4, 1);
        push_addr(edge_cnt + 1, 7);
        step();
        pad_rst_n = 1'b0;
        found     = 1'b0;
        prev_ena  = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (sel_addr == 10'd0) found = 1'b1;
            else prev_ena = sel_ena;
        end
        check_eq("clr_seen", 32'(found), 32'd1);
        check_eq("clr_ena", 32'(sel_ena), 32'd0);
        check_eq("pre_clr_ena", 32'(prev_ena), 32'd1);
        check_eq("clr_addr4", 32'(sel_addr4), 32'd0);
        m_addr = 0;
        step();
        pad_rst_n = 1'b1;
        repeat (10) step();

        // Count to 9 with enable high, settle, then block reset.
        repeat (9) inc_pulse(4, 4, 1'b1);
        repeat (8) step();
        push(edge_cnt + 1, K_E10, 1);
        push_addr(edge_cnt + 1, 9);
        step();
        rst = 1'b1;
        n = edge_cnt + 1;
        push_addr(n, 0);
        push(n, K_E10, 0);
        push(n, K_B10, 0);
        push(n, K_E4, 0);
        push(n, K_B4, 0);
        step();
        rst     = 1'b0;
        pad_ena = 1'b0;
        m_addr  = 0;
        repeat (4) step();

        // Single-cycle glitch, then a three-cycle pulse.
        inc_pulse(1, 8, GLITCH_COUNTS);
        inc_pulse(3, 8, 1'b1);
        repeat (10) step();

        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
